// File: rtl/subpel_block_scheduler.sv
// subpel_block_scheduler: runs one 8x8 HEVC luma sub-pel block through the
// interpolation datapath. It takes a request, gathers the 15x15 window row by
// row, starts the datapath, waits its fixed latency, and streams the 8x8
// result out as eight 64-bit rows.
// Optional feature: define SUBPEL_BYPASS_EN so that full-pel blocks (frac 0,0)
// skip the datapath and take the window centre directly.
module subpel_block_scheduler #(
    parameter int DP_LATENCY = 4   // cycles from dp_start to a valid dp_out_buffer, 1..15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [1:0]    req_frac_x,
    input  logic [1:0]    req_frac_y,
    input  logic          row_valid,
    output logic          row_ready,
    input  logic [119:0]  row_data,
    output logic [1799:0] dp_in_buffer,
    output logic [3:0]    dp_sel,
    output logic          dp_start,
    input  logic [511:0]  dp_out_buffer,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [63:0]   out_row,
    output logic          out_last,
    output logic          busy
);

    localparam int WIN   = 15;
    localparam int BLK   = 8;
    localparam int ROW_W = WIN * 8;
    localparam int OUT_W = BLK * 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_WAIT,
        ST_OUT
    } state_t;

    state_t state;
    state_t state_next;

    logic [3:0]                row_cnt;
    logic [3:0]                lat_cnt;
    logic [2:0]                out_idx;
    logic [3:0]                sel_q;
    logic [WIN-1:0][ROW_W-1:0] window;
    logic [BLK-1:0][OUT_W-1:0] result;
    logic                      row_last;
    logic                      bypass_hit;
    logic [BLK-1:0][OUT_W-1:0] bypass_blk;

    assign row_last     = (row_cnt == 4'd14);
    assign dp_in_buffer = window;
    assign dp_sel       = sel_q;
    assign out_row      = result[out_idx];

`ifdef SUBPEL_BYPASS_EN
    // Full-pel blocks need no filtering, so the block is just the window centre
    assign bypass_hit = (sel_q == 4'd0);

    // Rows 3..10, columns 3..10 of the window are the unfiltered 8x8 block
    always_comb begin
        bypass_blk = '0;
        for (int r = 0; r < BLK; r++) begin
            for (int c = 0; c < BLK; c++) begin
                bypass_blk[r][8*c +: 8] = window[r+3][8*(c+3) +: 8];
            end
        end
    end
`else
    assign bypass_hit = 1'b0;
    assign bypass_blk = '0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake decode; only terminal transfers change state
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        row_ready  = 1'b0;
        dp_start   = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        busy       = 1'b1;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                row_ready = 1'b1;
                if (row_valid && row_last) begin
                    state_next = bypass_hit ? ST_OUT : ST_START;
                end
            end
            ST_START: begin
                dp_start   = 1'b1;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (lat_cnt == 4'd0) begin
                    state_next = ST_OUT;
                end
            end
            ST_OUT: begin
                out_valid = 1'b1;
                out_last  = (out_idx == 3'd7);
                if (out_ready && out_idx == 3'd7) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Window, select, counters and result capture; window and select are only
    // written in IDLE/LOAD so they stay stable while the datapath works
    always_ff @(posedge clk) begin
        if (reset) begin
            row_cnt <= '0;
            lat_cnt <= '0;
            out_idx <= '0;
            sel_q   <= '0;
            window  <= '0;
            result  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        sel_q   <= {req_frac_y, req_frac_x};
                        row_cnt <= '0;
                    end
                end
                ST_LOAD: begin
                    if (row_valid) begin
                        window[row_cnt] <= row_data;
                        row_cnt         <= row_cnt + 4'd1;
                        if (row_last && bypass_hit) begin
                            result  <= bypass_blk;
                            out_idx <= '0;
                        end
                    end
                end
                ST_START: begin
                    lat_cnt <= 4'(DP_LATENCY - 1);
                end
                ST_WAIT: begin
                    if (lat_cnt == 4'd0) begin
                        result  <= dp_out_buffer;
                        out_idx <= '0;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                ST_OUT: begin
                    if (out_ready && out_idx != 3'd7) begin
                        out_idx <= out_idx + 3'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_subpel_block_scheduler.sv
// Testbench for subpel_block_scheduler: table of block requests with
// hand-computed select and last-row values, a small datapath model that
// answers exactly DP_LATENCY cycles after dp_start, plus hand-written reset
// sequences. Build with SUBPEL_BYPASS_EN to cover the full-pel bypass.
`timescale 1ns/1ps
module tb_subpel_block_scheduler;

    localparam int DP_LATENCY = 4;
    localparam int WIN = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_frac_x;
    logic [1:0]    req_frac_y;
    logic          row_valid;
    logic          row_ready;
    logic [119:0]  row_data;
    logic [1799:0] dp_in_buffer;
    logic [3:0]    dp_sel;
    logic          dp_start;
    logic [511:0]  dp_out_buffer;
    logic          out_valid;
    logic          out_ready;
    logic [63:0]   out_row;
    logic          out_last;
    logic          busy;

    int            tests_run = 0;
    int            tests_failed = 0;
    int            cycle = 0;
    int            dp_cnt = 0;
    int            total_starts = 0;
    logic [7:0]    cur_seed = 8'h00;

    typedef struct {
        logic [1:0]  fx;
        logic [1:0]  fy;
        logic [7:0]  seed;
        int          gap;
        int          stall_row;
        int          stall_len;
        bit          toggle;
        bit          req_in_load;
        logic [3:0]  exp_sel;
        logic [63:0] exp_row7;
    } vec_t;

    subpel_block_scheduler #(.DP_LATENCY(DP_LATENCY)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_frac_x    (req_frac_x),
        .req_frac_y    (req_frac_y),
        .row_valid     (row_valid),
        .row_ready     (row_ready),
        .row_data      (row_data),
        .dp_in_buffer  (dp_in_buffer),
        .dp_sel        (dp_sel),
        .dp_start      (dp_start),
        .dp_out_buffer (dp_out_buffer),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_row       (out_row),
        .out_last      (out_last),
        .busy          (busy)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Cycle counter used to time dp_start and the first output row
    always @(posedge clk) cycle <= cycle + 1;

    // Datapath latency model: counts cycles since dp_start
    always @(posedge clk) begin
        if (reset) dp_cnt <= 0;
        else if (dp_start) dp_cnt <= 1;
        else if (dp_cnt == DP_LATENCY) dp_cnt <= 0;
        else if (dp_cnt != 0) dp_cnt <= dp_cnt + 1;
    end

    // Count every dp_start pulse seen outside reset
    always @(posedge clk) begin
        if (!reset && dp_start) total_starts <= total_starts + 1;
    end

    // Datapath result: byte (r,c) = (r+c)^seed only in the valid cycle, junk otherwise
    always_comb begin
        dp_out_buffer = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                dp_out_buffer[64*r + 8*c +: 8] = (dp_cnt == DP_LATENCY) ? (8'(r + c) ^ cur_seed) : 8'hEE;
            end
        end
    end

    function automatic logic [7:0] pix(input int r, input int c, input logic [7:0] s);
        return 8'(16*r + c) ^ s;
    endfunction

    function automatic logic [119:0] mkrow(input int r, input logic [7:0] s);
        logic [119:0] v;
        v = '0;
        for (int c = 0; c < WIN; c++) v[8*c +: 8] = pix(r, c, s);
        return v;
    endfunction

    function automatic logic [63:0] exp_row(input int i, input logic [7:0] s, input bit bp);
        logic [63:0] v;
        v = '0;
        for (int c = 0; c < 8; c++) v[8*c +: 8] = bp ? pix(i + 3, c + 3, s) : (8'(i + c) ^ s);
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Runs one block; entered and left at a negedge with the DUT in IDLE
    task automatic applyStimulus(input vec_t v);
        bit               bp;
        int               acc, exp_start, exp_first, starts;
        int               rows_sent, gap_left, out_cnt, stall_left, guard;
        bit               holding, toggle_phase, first_out_seen;
        logic [63:0]      held;
        logic [1799:0]    exp_win;
        bp = 1'b0;
`ifdef SUBPEL_BYPASS_EN
        bp = (v.fx == 2'd0 && v.fy == 2'd0);
`endif
        cur_seed = v.seed;
        exp_win = '0;
        for (int r = 0; r < WIN; r++)
            for (int c = 0; c < WIN; c++)
                exp_win[120*r + 8*c +: 8] = pix(r, c, v.seed);

        row_valid  = 1'b0;
        req_valid  = 1'b1;
        req_frac_x = v.fx;
        req_frac_y = v.fy;
        guard = 0;
        while (req_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("req_accept", {63'd0, req_ready}, 64'd1);
        acc       = cycle;
        exp_start = acc + 16 + 14 * v.gap;
        exp_first = bp ? exp_start : exp_start + 1 + DP_LATENCY;

        rows_sent = 0; gap_left = 0; out_cnt = 0; stall_left = v.stall_len;
        holding = 1'b0; toggle_phase = 1'b0; first_out_seen = 1'b0; starts = 0;
        held = '0;
        guard = 0;
        @(negedge clk);
        if (!v.req_in_load) req_valid = 1'b0;
        while (out_cnt < 8 && guard < 500) begin
            if (v.req_in_load && row_ready)
                checkOutput("req_ready_in_load", {63'd0, req_ready}, 64'd0);
            if (dp_start) begin
                starts++;
                if (starts == 1) begin
                    checkOutput("dp_start_cycle", 64'(cycle), 64'(exp_start));
                    checkOutput("dp_sel", {60'd0, dp_sel}, {60'd0, v.exp_sel});
                    checkOutput("window", {63'd0, dp_in_buffer == exp_win}, 64'd1);
                end
            end
            if (out_valid) begin
                if (!first_out_seen) begin
                    first_out_seen = 1'b1;
                    checkOutput("first_out_cycle", 64'(cycle), 64'(exp_first));
                    if (!bp) checkOutput("dp_sel_hold", {60'd0, dp_sel}, {60'd0, v.exp_sel});
                end
                if (holding) checkOutput("stall_hold", out_row, held);
                checkOutput($sformatf("out_row%0d", out_cnt), out_row,
                            (out_cnt == 7) ? v.exp_row7 : exp_row(out_cnt, v.seed, bp));
                checkOutput($sformatf("out_last%0d", out_cnt), {63'd0, out_last}, 64'(out_cnt == 7));
            end

            if (row_ready && rows_sent < 15) begin
                if (gap_left > 0) begin
                    row_valid = 1'b0;
                    row_data  = 120'({$urandom(), $urandom(), $urandom(), $urandom()});
                    gap_left--;
                end else begin
                    row_valid = 1'b1;
                    row_data  = mkrow(rows_sent, v.seed);
                    rows_sent++;
                    gap_left  = v.gap;
                end
            end else begin
                row_valid = 1'b1;
                row_data  = 120'({$urandom(), $urandom(), $urandom(), $urandom()});
            end
            if (!row_ready && rows_sent == 15) req_valid = 1'b0;

            if (out_valid) begin
                if (out_cnt == v.stall_row && stall_left > 0) begin
                    out_ready = 1'b0;
                    stall_left--;
                end else if (v.toggle && out_cnt > v.stall_row) begin
                    out_ready    = toggle_phase;
                    toggle_phase = !toggle_phase;
                end else begin
                    out_ready = 1'b1;
                end
                if (out_ready) begin
                    out_cnt++;
                    holding = 1'b0;
                end else begin
                    holding = 1'b1;
                    held    = out_row;
                end
            end else begin
                out_ready = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            guard++;
        end
        if (out_cnt < 8) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL block_timeout: got %0d rows, expected 8", out_cnt);
        end
        row_valid = 1'b0;
        out_ready = 1'b0;
        req_valid = 1'b0;
        checkOutput("start_pulses", 64'(starts), bp ? 64'd0 : 64'd1);
        checkOutput("req_ready_after", {63'd0, req_ready}, 64'd1);
        checkOutput("busy_after", {63'd0, busy}, 64'd0);
    endtask

    // Watchdog so the run always terminates
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence: reset check, table of blocks, reset during LOAD
    initial begin
        vec_t vecs[5];
        int   starts_before;

        vecs[0] = '{fx: 2'd2, fy: 2'd1, seed: 8'h00, gap: 0, stall_row: -1, stall_len: 0,
                    toggle: 1'b0, req_in_load: 1'b0, exp_sel: 4'h6, exp_row7: 64'h0E0D0C0B0A090807};
        vecs[1] = '{fx: 2'd3, fy: 2'd2, seed: 8'h55, gap: 0, stall_row: 3, stall_len: 5,
                    toggle: 1'b1, req_in_load: 1'b0, exp_sel: 4'hB, exp_row7: 64'h5B58595E5F5C5D52};
        vecs[2] = '{fx: 2'd1, fy: 2'd3, seed: 8'hA0, gap: 2, stall_row: -1, stall_len: 0,
                    toggle: 1'b0, req_in_load: 1'b1, exp_sel: 4'hD, exp_row7: 64'hAEADACABAAA9A8A7};
        vecs[3] = '{fx: 2'd0, fy: 2'd1, seed: 8'h0F, gap: 1, stall_row: 0, stall_len: 2,
                    toggle: 1'b0, req_in_load: 1'b0, exp_sel: 4'h4, exp_row7: 64'h0102030405060708};
`ifdef SUBPEL_BYPASS_EN
        vecs[4] = '{fx: 2'd0, fy: 2'd0, seed: 8'h00, gap: 0, stall_row: -1, stall_len: 0,
                    toggle: 1'b0, req_in_load: 1'b0, exp_sel: 4'h0, exp_row7: 64'hAAA9A8A7A6A5A4A3};
`else
        vecs[4] = '{fx: 2'd0, fy: 2'd0, seed: 8'h00, gap: 0, stall_row: -1, stall_len: 0,
                    toggle: 1'b0, req_in_load: 1'b0, exp_sel: 4'h0, exp_row7: 64'h0E0D0C0B0A090807};
`endif

        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_valid  = 1'($urandom_range(0, 1));
            req_frac_x = 2'($urandom_range(0, 3));
            req_frac_y = 2'($urandom_range(0, 3));
            row_valid  = 1'($urandom_range(0, 1));
            row_data   = 120'({$urandom(), $urandom(), $urandom(), $urandom()});
            out_ready  = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        checkOutput("rst_req_ready", {63'd0, req_ready}, 64'd1);
        checkOutput("rst_busy", {63'd0, busy}, 64'd0);
        checkOutput("rst_row_ready", {63'd0, row_ready}, 64'd0);
        checkOutput("rst_dp_start", {63'd0, dp_start}, 64'd0);
        checkOutput("rst_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("rst_out_last", {63'd0, out_last}, 64'd0);
        checkOutput("rst_dp_sel", {60'd0, dp_sel}, 64'd0);
        checkOutput("rst_dp_in_buffer", {63'd0, dp_in_buffer == '0}, 64'd1);

        reset     = 1'b0;
        req_valid = 1'b0;
        row_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            $display("[TB] block %0d: frac_x=%0d frac_y=%0d", i, vecs[i].fx, vecs[i].fy);
            applyStimulus(vecs[i]);
        end

        $display("[TB] reset during LOAD after 7 rows");
        starts_before = total_starts;
        cur_seed   = 8'h77;
        req_valid  = 1'b1;
        req_frac_x = 2'd1;
        req_frac_y = 2'd2;
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            row_valid = 1'b1;
            row_data  = mkrow(i, 8'h77);
            @(negedge clk);
        end
        reset     = 1'b1;
        row_valid = 1'b1;
        row_data  = mkrow(7, 8'h77);
        @(negedge clk);
        checkOutput("midrst_busy", {63'd0, busy}, 64'd0);
        checkOutput("midrst_req_ready", {63'd0, req_ready}, 64'd1);
        checkOutput("midrst_row_ready", {63'd0, row_ready}, 64'd0);
        checkOutput("midrst_window", {63'd0, dp_in_buffer == '0}, 64'd1);
        checkOutput("midrst_dp_sel", {60'd0, dp_sel}, 64'd0);
        reset     = 1'b0;
        row_valid = 1'b0;
        applyStimulus(vecs[3]);
        checkOutput("midrst_total_starts", 64'(total_starts - starts_before), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/subpel_block_scheduler.md
Name: subpel_block_scheduler

Overview:
- Sequences one 8x8 HEVC luma sub-pixel prediction through the subpixel interpolation datapath.
- Accepts a block request carrying a quarter-pel fraction, then gathers the 15x15 integer-pixel window row by row.
- Presents the window and filter select to the datapath and waits a fixed latency.
- Captures the 8x8 result and streams it out as eight 64-bit rows under valid/ready handshakes.

Parameters:
- DP_LATENCY, 4: cycles from dp_start to dp_out_buffer valid; legal range 1..15.
- WIN, 15: window side in pixels (8 + 7 filter taps); fixed.
- BLK, 8: output block side in pixels; fixed.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  block request present.
- req_ready  out  1  scheduler can accept a request; high only in IDLE.
- req_frac_x  in  2  horizontal quarter-pel fraction, 0..3.
- req_frac_y  in  2  vertical quarter-pel fraction, 0..3.
- row_valid  in  1  window row present.
- row_ready  out  1  high only in LOAD.
- row_data  in  120  one window row; column c in bits [8c +: 8].
- dp_in_buffer  out  1800  window to datapath; row r, column c at bits [120r + 8c +: 8].
- dp_sel  out  4  filter select {frac_y, frac_x}.
- dp_start  out  1  one-cycle pulse; window and select are valid.
- dp_out_buffer  in  512  datapath result; row r, column c at bits [64r + 8c +: 8].
- out_valid  out  1  output row present.
- out_ready  in  1  consumer accepts the output row.
- out_row  out  64  current output row.
- out_last  out  1  high with row 7.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- States are IDLE, LOAD, START, WAIT, OUT.
- Reset values: state=IDLE; req_ready=1; row_ready, dp_start, out_valid, out_last and busy=0; dp_sel=0; dp_in_buffer=0; row and latency counters=0.
- Reset mid-operation returns to IDLE on the next edge. Partial window or output data is discarded, with no further handshakes.
- IDLE: on req_valid && req_ready, latch dp_sel={frac_y,frac_x}, clear row_cnt, and go to LOAD.
- LOAD: each row_valid && row_ready writes row_data into row slot row_cnt and increments row_cnt. After the row_cnt=14 transfer, go to START. row_valid is ignored outside LOAD.
- START: drive dp_start=1 for exactly one cycle, load lat_cnt=DP_LATENCY-1, and go to WAIT.
- dp_in_buffer and dp_sel hold stable from START until the result is captured.
- WAIT: decrement lat_cnt each cycle. When lat_cnt=0, capture dp_out_buffer into the output register, set out_idx=0, and go to OUT. With DP_LATENCY=1, capture occurs on the cycle after dp_start.
- OUT: out_valid=1 and out_row=result[64*out_idx +: 64]. out_last=1 when out_idx=7.
- OUT: out_row stays stable while out_valid && !out_ready (backpressure of any length).
- OUT: each out_valid && out_ready advances out_idx. The transfer with out_last=1 returns to IDLE, with req_ready=1 on the next cycle.
- Consecutive requests are not overlapped. Minimum cycles per block = 1 + 15 + 1 + DP_LATENCY + 8.
- A req_valid arriving while busy is held off by req_ready=0, and the requester must keep its fields stable.
- row_cnt and out_idx never wrap. Only the terminal transfer changes state.

Optional Feature:
- Macro: SUBPEL_BYPASS_EN.
- Defined, request with frac_x=0 and frac_y=0: after LOAD, skip START and WAIT. The output register is filled directly from window rows 3..10, columns 3..10, and the block goes to OUT the next cycle. dp_start is never pulsed for that block.
- Defined, any other fraction: behaviour is unchanged.
- Not defined: every request, including full-pel, goes through START and WAIT.

Test Plan:
- Reset check: assert reset for 3 cycles with random inputs -> all outputs at reset values, req_ready=1, busy=0.
- Basic block: request frac (x=2,y=1); stream 15 rows with pixel(r,c)=16r+c, no gaps -> dp_sel=4'h6; dp_start is a single pulse 16 cycles after request acceptance; dp_in_buffer byte (r,c)=16r+c. With a model returning result byte (r,c)=r+c after DP_LATENCY=4, out_row[7:0] values are 0,1,...,7, out_last only on row 7, and req_ready returns 1 the following cycle.
- Backpressure: hold out_ready low 5 cycles at row 3, and toggle it every other cycle for the remaining rows -> out_row constant while stalled, no row skipped or duplicated, 8 transfers total.
- Input gaps: deassert row_valid for 2 cycles after every row; assert req_valid during LOAD -> rows land in correct slots, req_ready stays 0, and the second request is accepted only after out_last.
- Reset mid-LOAD after 7 rows, then a fresh request with 15 rows -> no dp_start before the new 15th row; output matches the new data only.
- With SUBPEL_BYPASS_EN, frac (0,0) and pixel(r,c)=16r+c -> no dp_start; row 0 out_row bytes are 0x33..0x3A; first out_valid 1 cycle after the last row.
